// File: rtl/control_sequencer.sv
// Multi-cycle Moore control unit for the CPU datapath: fetch, decode and execute
// sequencing with one-hot register, bus, ALU and memory strobes.
module control_sequencer (
    input  logic        clk,
    input  logic        clr,
    input  logic        run,
    input  logic [31:0] IR,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        HIin,
    output logic        LOin,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic [12:0] alu_op,
    output logic        illegal,
    output logic        halted
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    state_t state_q, state_d;

    logic [4:0]  opcode;
    logic [15:0] ra_oh, rb_oh, rc_oh;
    logic        is_bin, is_muldiv, is_unary, is_nop, is_halt, is_undef;
    logic [12:0] alu_sel;
    state_t      done_state;
    logic        unused_ir;

    assign opcode    = IR[31:27];
    assign ra_oh     = 16'h0001 << IR[26:23];
    assign rb_oh     = 16'h0001 << IR[22:19];
    assign rc_oh     = 16'h0001 << IR[18:15];
    assign unused_ir = ^IR[14:0];

    // IR is only meaningful from T3 on, once the datapath has captured it at the end of T2.
    always_comb begin
        is_bin    = 1'b0;
        is_muldiv = 1'b0;
        is_unary  = 1'b0;
        is_nop    = 1'b0;
        is_halt   = 1'b0;
        alu_sel   = 13'h0000;
        case (opcode)
            5'b00011: begin is_bin    = 1'b1; alu_sel = 13'h0001; end
            5'b00100: begin is_bin    = 1'b1; alu_sel = 13'h0002; end
            5'b00101: begin is_bin    = 1'b1; alu_sel = 13'h0004; end
            5'b00110: begin is_bin    = 1'b1; alu_sel = 13'h0008; end
            5'b00111: begin is_bin    = 1'b1; alu_sel = 13'h0010; end
            5'b01000: begin is_bin    = 1'b1; alu_sel = 13'h0020; end
            5'b01001: begin is_bin    = 1'b1; alu_sel = 13'h0040; end
            5'b01010: begin is_bin    = 1'b1; alu_sel = 13'h0080; end
            5'b01011: begin is_bin    = 1'b1; alu_sel = 13'h0100; end
            5'b01111: begin is_muldiv = 1'b1; alu_sel = 13'h0200; end
            5'b10000: begin is_muldiv = 1'b1; alu_sel = 13'h0400; end
            5'b10001: begin is_unary  = 1'b1; alu_sel = 13'h0800; end
            5'b10010: begin is_unary  = 1'b1; alu_sel = 13'h1000; end
            5'b11010: is_nop  = 1'b1;
            5'b11011: is_halt = 1'b1;
            default:  ;
        endcase
    end

    assign is_undef   = ~(is_bin | is_muldiv | is_unary | is_nop | is_halt);
    assign done_state = run ? S_T0 : S_IDLE;

    always_ff @(posedge clk) begin
        if (clr) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = run ? S_T0 : S_IDLE;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3: begin
                if (is_halt)                             state_d = S_HALT;
                else if (is_bin | is_muldiv | is_unary)  state_d = S_T4;
                else                                     state_d = done_state;
            end
            S_T4:   state_d = (is_bin | is_muldiv) ? S_T5 : done_state;
            S_T5:   state_d = is_muldiv ? S_T6 : done_state;
            S_T6:   state_d = done_state;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        PCout    = 1'b0;
        PCin     = 1'b0;
        IncPC    = 1'b0;
        MARin    = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        Rin      = 16'h0000;
        Rout     = 16'h0000;
        alu_op   = 13'h0000;
        illegal  = 1'b0;
        halted   = 1'b0;
        case (state_q)
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            S_T3: begin
                if (is_bin) begin
                    Rout = rb_oh; Yin = 1'b1;
                end else if (is_muldiv) begin
                    Rout = ra_oh; Yin = 1'b1;
                end else if (is_unary) begin
                    Rout = rb_oh; alu_op = alu_sel; Zin = 1'b1;
                end else if (is_undef) begin
                    illegal = 1'b1;
                end
            end
            S_T4: begin
                if (is_bin) begin
                    Rout = rc_oh; alu_op = alu_sel; Zin = 1'b1;
                end else if (is_muldiv) begin
                    Rout = rb_oh; alu_op = alu_sel; Zin = 1'b1;
                end else if (is_unary) begin
                    Zlowout = 1'b1; Rin = ra_oh;
                end
            end
            S_T5: begin
                if (is_bin) begin
                    Zlowout = 1'b1; Rin = ra_oh;
                end else if (is_muldiv) begin
                    Zlowout = 1'b1; LOin = 1'b1;
                end
            end
            S_T6: begin
                Zhighout = 1'b1; HIin = 1'b1;
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule
